pipelined_adder: RTL
====================

PIPELINED_ADDER -- requirements
Module: pipelined_adder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, operand width in bits.
REQ-002 SHALL have parameter STAGES, default 2, number of carry-chain segments and pipeline stages; legal range 1..DATA_WIDTH, and DATA_WIDTH % STAGES == 0. Illegal values are rejected by an elaboration-time error.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  clock; all state updates on the rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 in_valid  input  1  operands a, b and cin are valid this cycle.
REQ-007 in_ready  output  1  the block accepts the operands this cycle.
REQ-008 a  input  DATA_WIDTH  operand A, unsigned.
REQ-009 b  input  DATA_WIDTH  operand B, unsigned.
REQ-010 cin  input  1  carry-in.
REQ-011 out_valid  output  1  y holds a result.
REQ-012 out_ready  input  1  the consumer takes y this cycle.
REQ-013 y  output  DATA_WIDTH+1  sum a+b+cin; the MSB is the carry-out.

Function
REQ-014 SHALL split the operands into STAGES segments of W=DATA_WIDTH/STAGES bits each; segment 0 is the LSBs.
REQ-015 In stage k, SHALL add segment k of a, segment k of b and the carry registered by stage k-1; stage 0 uses cin.
- Operand segments above k are delayed by skew registers.
- Sum segments below k are delayed by deskew registers.
- The result is aligned at the output.
REQ-016 SHALL produce y = (a + b + cin) exactly, with no truncation; y[DATA_WIDTH] is the final carry.
REQ-017 Transfers:
- An input transfer occurs when in_valid && in_ready.
- An output transfer occurs when out_valid && out_ready.
REQ-018 SHALL define stall = out_valid && !out_ready; while stall is high, every pipeline register, including valid bits, holds its value.
REQ-019 in_ready SHALL equal !stall, combinationally; in_ready SHALL NOT depend on in_valid.
REQ-020 Latency: with no stall, SHALL assert out_valid, with the matching y, exactly STAGES cycles after the input-transfer edge.
REQ-021 Throughput: SHALL sustain one transfer per cycle when out_ready is held high.
REQ-022 Each stage SHALL carry a valid bit. When there is no stall, stage 0 captures in_valid && in_ready, and a bubble advances like data. Bubbles are not compressed.
REQ-023 y and out_valid SHALL come directly from registers, with no combinational path from the inputs.
REQ-024 While stall is high, y SHALL stay stable and out_valid SHALL stay high.
REQ-025 Results SHALL leave in acceptance order; no transfer is lost or duplicated.
REQ-026 When STAGES==1, SHALL behave as one registered full-width adder with latency 1.
REQ-027 Wrap-around: an all-ones operand with a carry SHALL propagate through every stage, for example a=2^DATA_WIDTH-1, b=0, cin=1 gives y=2^DATA_WIDTH.

Reset
REQ-028 While rst is high, SHALL clear all stage valid bits; out_valid=0 and y=0 after the edge.
REQ-029 in_ready SHALL be 1 during and after reset.
REQ-030 Operands presented in a cycle with rst high SHALL be discarded.
REQ-031 Reset in mid-operation SHALL discard all in-flight results, whether or not a stall is in progress.
REQ-032 Data registers other than y need not be reset, but SHALL never show through while their valid bit is 0.

Verification
REQ-033 DATA_WIDTH=8, STAGES=2, out_ready=1: a=0xFF, b=0x01, cin=0 -> out_valid and y=0x100 exactly 2 cycles after acceptance.
REQ-034 Cross-segment carry: a=0x0F, b=0x01, cin=0 -> y=0x010; a=0x7F, b=0x80, cin=1 -> y=0x100.
REQ-035 Back-to-back: 4 consecutive transfers (1+2, 3+4, 0xFF+0xFF, 0+0 with cin=1) -> y = 0x003, 0x007, 0x1FE, 0x001 on 4 consecutive cycles.
REQ-036 Backpressure: drop out_ready for 3 cycles while results are in flight -> in_ready=0, y held stable, and all results delivered in order with none lost.
REQ-037 Reset mid-operation: assert rst for 1 cycle with 2 results in flight -> out_valid=0 and y=0 next cycle, in_ready=1, and no stale result ever appears.
REQ-038 Parameter sweep: STAGES in {1, 2, 4, 8} at DATA_WIDTH=8, and DATA_WIDTH=32 with STAGES=4 -> latency equals STAGES, and 10k random transfers match the model a+b+cin under random out_ready.

Source files
------------

// File: rtl/pipelined_adder.sv
// Pipelined ripple adder: the operands are cut into STAGES equal segments and
// each pipeline stage adds one segment with the carry registered by the stage
// before it. Upper operand segments travel forward in skew registers; finished
// sum segments travel forward alongside, so the full sum is aligned at the last
// stage. A single stall (result valid but not taken) freezes the whole pipe.
module pipelined_adder #(
    parameter int DATA_WIDTH = 8,
    parameter int STAGES     = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic                  cin,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH:0]   y
);

    // Segment width; guarded so an illegal STAGES reaches the error below
    // instead of a division by zero.
    localparam int W = (STAGES > 0) ? (DATA_WIDTH / STAGES) : DATA_WIDTH;
    localparam int REM = (STAGES > 0) ? (DATA_WIDTH % STAGES) : 1;

    if ((STAGES < 1) || (STAGES > DATA_WIDTH) || (REM != 0)) begin : g_bad_params
        $error("pipelined_adder: STAGES must be in 1..DATA_WIDTH and divide DATA_WIDTH");
    end

    logic stall;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        // Width of the partial sum held by this stage: segments 0..k.
        localparam int SW = (k + 1) * W;

        logic          vld_p;
        logic          carry_p;
        logic [SW-1:0] sum_p;

        logic [W-1:0]  seg_a;
        logic [W-1:0]  seg_b;
        logic          c_in;
        logic          v_in;
        logic [W:0]    seg_sum;
        logic [SW-1:0] sum_next;

        if (k == 0) begin : g_src
            assign seg_a = a[W-1:0];
            assign seg_b = b[W-1:0];
            assign c_in  = cin;
            assign v_in  = in_valid;
        end else begin : g_src
            assign seg_a = g_stage[k-1].g_fwd.a_p[W-1:0];
            assign seg_b = g_stage[k-1].g_fwd.b_p[W-1:0];
            assign c_in  = g_stage[k-1].carry_p;
            assign v_in  = g_stage[k-1].vld_p;
        end

        assign seg_sum = {1'b0, seg_a} + {1'b0, seg_b} + {{W{1'b0}}, c_in};

        if (k == 0) begin : g_sum
            assign sum_next = seg_sum[W-1:0];
        end else begin : g_sum
            assign sum_next = {seg_sum[W-1:0], g_stage[k-1].sum_p};
        end

        // Stage valid bit: bubbles advance like data, reset flushes the stage.
        always_ff @(posedge clk) begin
            if (rst) begin
                vld_p <= 1'b0;
            end else if (!stall) begin
                vld_p <= v_in;
            end
        end

        if (k < STAGES - 1) begin : g_fwd
            // Segments k+1..STAGES-1 of each operand still waiting for their stage.
            localparam int UW = (STAGES - 1 - k) * W;

            logic [UW-1:0] a_p;
            logic [UW-1:0] b_p;

            if (k == 0) begin : g_load
                // Skew registers fed straight from the operand inputs.
                always_ff @(posedge clk) begin
                    if (!stall) begin
                        a_p <= a[DATA_WIDTH-1:W];
                        b_p <= b[DATA_WIDTH-1:W];
                    end
                end
            end else begin : g_load
                // Skew registers drop the segment consumed by this stage.
                always_ff @(posedge clk) begin
                    if (!stall) begin
                        a_p <= g_stage[k-1].g_fwd.a_p[UW+W-1:W];
                        b_p <= g_stage[k-1].g_fwd.b_p[UW+W-1:W];
                    end
                end
            end
        end

        if (k < STAGES - 1) begin : g_data
            // Inner stage data: partial sum and carry, meaningful only with vld_p.
            always_ff @(posedge clk) begin
                if (!stall) begin
                    sum_p   <= sum_next;
                    carry_p <= seg_sum[W];
                end
            end
        end else begin : g_data
            // Output stage data doubles as y: cleared by reset and loaded with
            // zero for a bubble so stale inner data never reaches the port.
            always_ff @(posedge clk) begin
                if (rst) begin
                    sum_p   <= '0;
                    carry_p <= 1'b0;
                end else if (!stall) begin
                    if (v_in) begin
                        sum_p   <= sum_next;
                        carry_p <= seg_sum[W];
                    end else begin
                        sum_p   <= '0;
                        carry_p <= 1'b0;
                    end
                end
            end
        end
    end

    assign stall     = g_stage[STAGES-1].vld_p && !out_ready;
    // Reset flushes the pipe, so operands offered during reset are simply
    // dropped and the block reports ready throughout.
    assign in_ready  = !stall || rst;
    assign out_valid = g_stage[STAGES-1].vld_p;
    assign y         = {g_stage[STAGES-1].carry_p, g_stage[STAGES-1].sum_p};

endmodule
